// File: rtl/branch_pkg.sv
// Shared types for the branch resolve stage:
// op encodings, predictor reset value, helpers.
package branch_pkg;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'd0,
        OP_BNE  = 3'd1,
        OP_BLEZ = 3'd2,
        OP_BGTZ = 3'd3,
        OP_BLTZ = 3'd4,
        OP_BGEZ = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    // What the result register does on a given edge
    typedef enum logic [1:0] {
        ACT_IDLE  = 2'd0,
        ACT_CAPT  = 2'd1,
        ACT_HOLD  = 2'd2,
        ACT_FLUSH = 2'd3
    } act_e;

    // Operand facts the compare modes are built from
    typedef struct packed {
        logic eq;
        logic neg;
        logic zero;
    } cmp_t;

    localparam logic [1:0]  PHT_RST = 2'b01;
    localparam logic [1:0]  PHT_MAX = 2'b11;
    localparam logic [1:0]  PHT_MIN = 2'b00;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic resolve(
        input op_e  op,
        input cmp_t c
    );
        logic t;
        t = 1'b0;
        case (op)
            OP_BEQ:  t = c.eq;
            OP_BNE:  t = !c.eq;
            OP_BLEZ: t = c.neg || c.zero;
            OP_BGTZ: t = !c.neg && !c.zero;
            OP_BLTZ: t = c.neg;
            OP_BGEZ: t = !c.neg;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // 2-bit saturating up/down counter step
    function automatic logic [1:0] sat2(
        input logic [1:0] ctr,
        input logic       up
    );
        logic [1:0] n;
        n = ctr;
        if (up) begin
            if (ctr != PHT_MAX) n = ctr + 2'd1;
        end else begin
            if (ctr != PHT_MIN) n = ctr - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2-bit counters,
// async read for fetch, sync saturating update.
module bp_pht
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr [DEPTH];

    // Read is combinational so a same-edge update
    // is only seen after that edge.
    always_comb begin
        rd_data = ctr[rd_idx];
    end

    // Counter array with weakly-not-taken reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= PHT_RST;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= sat2(ctr[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolve stage: 1-cycle compare, redirect,
// mispredict flag/count and PHT training.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PC_W      = 32,
    parameter int PHT_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  target,
    input  logic             pred_in,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             fetch_pred_taken,
    output logic             out_valid,
    output logic             taken,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [15:0]      mispredict_cnt
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    act_e             act;
    cmp_t             cmp;
    logic             tk_d;
    logic             mp_d;
    logic [PC_W-1:0]  seq_pc;
    logic [PC_W-1:0]  nxt_pc;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       fetch_ctr;
    logic             capture;
    logic             unused_fetch;

    // Flush beats stall beats a new branch
    always_comb begin
        act = ACT_IDLE;
        unique case (1'b1)
            flush:
                act = ACT_FLUSH;
            !flush && stall:
                act = ACT_HOLD;
            !flush && !stall && in_valid:
                act = ACT_CAPT;
            default:
                act = ACT_IDLE;
        endcase
    end

    // Resolve the incoming branch
    always_comb begin
        cmp.eq   = (a == b);
        cmp.neg  = a[WIDTH-1];
        cmp.zero = (a == '0);
        tk_d     = resolve(op_e'(op), cmp);
        mp_d     = tk_d ^ pred_in;
        seq_pc   = pc + PC_W'(4);
        nxt_pc   = tk_d ? target : seq_pc;
    end

    // Predictor indexing (word-aligned PCs)
    always_comb begin
        capture      = (act == ACT_CAPT);
        fetch_idx    = fetch_pc[IDX_W+1:2];
        upd_idx      = pc[IDX_W+1:2];
        unused_fetch = ^{fetch_pc};
    end

    bp_pht #(
        .DEPTH (PHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (fetch_idx),
        .rd_data  (fetch_ctr),
        .wr_en    (capture),
        .wr_idx   (upd_idx),
        .wr_taken (tk_d)
    );

    assign fetch_pred_taken = fetch_ctr[1];

    // Result register: capture, drop valid, or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            taken       <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            unique case (act)
                ACT_CAPT: begin
                    out_valid   <= 1'b1;
                    taken       <= tk_d;
                    mispredict  <= mp_d;
                    redirect_pc <= nxt_pc;
                end
                ACT_IDLE, ACT_FLUSH: begin
                    out_valid <= 1'b0;
                end
                ACT_HOLD: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating mispredict counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_cnt <= '0;
        end else if (capture && mp_d) begin
            if (mispredict_cnt != CNT_MAX) begin
                mispredict_cnt <= mispredict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with
// hand-computed expectations.
module tb_branch_resolver;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred_in;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic        out_valid;
    logic        taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_cnt;

    int checks   = 0;
    int failures = 0;

    branch_resolver #(
        .WIDTH     (32),
        .PC_W      (32),
        .PHT_DEPTH (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .stall            (stall),
        .flush            (flush),
        .op               (op),
        .a                (a),
        .b                (b),
        .pc               (pc),
        .target           (target),
        .pred_in          (pred_in),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .out_valid        (out_valid),
        .taken            (taken),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .mispredict_cnt   (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(
        input logic [2:0]  o,
        input logic [31:0] av,
        input logic [31:0] bv,
        input logic [31:0] p,
        input logic [31:0] t,
        input logic        pr
    );
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        pc       = p;
        target   = t;
        pred_in  = pr;
    endtask

    task automatic res(
        input string       tag,
        input logic        ov,
        input logic        tk,
        input logic        mp,
        input logic [31:0] rpc,
        input logic [15:0] cnt
    );
        chk({tag, "_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, "_taken"}, 32'(taken), 32'(tk));
        chk({tag, "_misp"}, 32'(mispredict), 32'(mp));
        chk({tag, "_rpc"}, redirect_pc, rpc);
        chk({tag, "_cnt"}, 32'(mispredict_cnt), 32'(cnt));
    endtask

    task automatic rst_pulse();
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        #1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        op       = 3'd0;
        a        = 32'd0;
        b        = 32'd0;
        pc       = 32'd0;
        target   = 32'd0;
        pred_in  = 1'b0;
        fetch_pc = 32'd0;
        #1;
        rst = 1'b1;
        #1;
        res("reset", 0, 0, 0, 32'h0, 16'd0);
        chk("reset_fpred", 32'(fetch_pred_taken), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // BEQ taken, predicted not-taken
        drv(3'd0, 32'h1234, 32'h1234, 32'h100, 32'h200, 0);
        fetch_pc = 32'h100;
        #1;
        chk("same_cyc_fpred", 32'(fetch_pred_taken), 32'd0);
        tick();
        res("beq", 1, 1, 1, 32'h200, 16'd1);
        chk("beq_fpred", 32'(fetch_pred_taken), 32'd1);

        // idle edge: valid drops, rest holds
        in_valid = 1'b0;
        tick();
        res("idle", 0, 1, 1, 32'h200, 16'd1);

        drv(3'd1, 32'd1, 32'd1, 32'h104, 32'h300, 0);
        tick();
        res("bne", 1, 0, 0, 32'h108, 16'd1);

        drv(3'd4, 32'h8000_0000, 32'd0, 32'h108, 32'h500, 1);
        tick();
        res("bltz", 1, 1, 0, 32'h500, 16'd1);

        drv(3'd3, 32'd0, 32'd0, 32'h10C, 32'h700, 1);
        tick();
        res("bgtz0", 1, 0, 1, 32'h110, 16'd2);

        drv(3'd2, 32'd0, 32'd9, 32'h110, 32'h600, 1);
        tick();
        res("blez0", 1, 1, 0, 32'h600, 16'd2);

        drv(3'd5, 32'hFFFF_FFFF, 32'd0, 32'h114, 32'h800, 0);
        tick();
        res("bgez_m1", 1, 0, 0, 32'h118, 16'd2);

        drv(3'd3, 32'h7FFF_FFFF, 32'd0, 32'h118, 32'hA00, 1);
        tick();
        res("bgtz_max", 1, 1, 0, 32'hA00, 16'd2);

        drv(3'd6, 32'd5, 32'd5, 32'h11C, 32'hB00, 0);
        tick();
        res("rsv6", 1, 0, 0, 32'h120, 16'd2);

        drv(3'd7, 32'd5, 32'd5, 32'h120, 32'hC00, 1);
        tick();
        res("rsv7", 1, 0, 1, 32'h124, 16'd3);

        drv(3'd1, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'h4, 0);
        tick();
        res("pc_wrap", 1, 0, 0, 32'h0, 16'd3);

        // training at pc 0x40 from cold
        rst_pulse();
        fetch_pc = 32'h40;
        drv(3'd0, 32'd7, 32'd7, 32'h40, 32'h80, 1);
        #1;
        chk("pht_cold", 32'(fetch_pred_taken), 32'd0);
        tick();
        chk("pht_t1", 32'(fetch_pred_taken), 32'd1);
        tick();
        tick();
        tick();
        chk("pht_t4", 32'(fetch_pred_taken), 32'd1);
        res("pht_t4", 1, 1, 0, 32'h80, 16'd0);
        drv(3'd1, 32'd7, 32'd7, 32'h40, 32'h80, 0);
        tick();
        chk("pht_nt1", 32'(fetch_pred_taken), 32'd1);
        res("pht_nt1", 1, 0, 0, 32'h44, 16'd0);
        tick();
        chk("pht_nt2", 32'(fetch_pred_taken), 32'd0);

        // stall holds everything
        drv(3'd0, 32'd3, 32'd3, 32'h204, 32'h900, 0);
        fetch_pc = 32'h204;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            res("stall", 1, 0, 0, 32'h44, 16'd0);
            chk("stall_fpred", 32'(fetch_pred_taken), 32'd0);
        end

        // flush kills, with and without stall
        flush = 1'b1;
        tick();
        res("flush_st", 0, 0, 0, 32'h44, 16'd0);
        chk("flush_st_fp", 32'(fetch_pred_taken), 32'd0);
        stall = 1'b0;
        tick();
        res("flush", 0, 0, 0, 32'h44, 16'd0);
        chk("flush_fp", 32'(fetch_pred_taken), 32'd0);

        flush = 1'b0;
        tick();
        res("post_flush", 1, 1, 1, 32'h900, 16'd1);
        chk("post_flush_fp", 32'(fetch_pred_taken), 32'd1);

        // async reset between edges
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        res("async_rst", 0, 0, 0, 32'h0, 16'd0);
        for (int i = 0; i < 16; i++) begin
            fetch_pc = 32'(i) << 2;
            #0.1;
            chk("rst_fpred", 32'(fetch_pred_taken), 32'd0);
        end
        tick();
        rst = 1'b0;

        // first capture after reset is cold
        fetch_pc = 32'h40;
        drv(3'd0, 32'd1, 32'd1, 32'h40, 32'h80, 0);
        tick();
        res("cold", 1, 1, 1, 32'h80, 16'd1);
        chk("cold_fp", 32'(fetch_pred_taken), 32'd1);

        // counter saturation
        rst_pulse();
        drv(3'd0, 32'd2, 32'd2, 32'h300, 32'h400, 0);
        repeat (65535) @(posedge clk);
        #1;
        chk("cnt_ffff", 32'(mispredict_cnt), 32'hFFFF);
        tick();
        res("cnt_sat", 1, 1, 1, 32'h400, 16'hFFFF);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
